// File: rtl/bcd_countdown_if.sv
// rtl/bcd_countdown_if.sv - control/status bundle for the BCD countdown timer
//
// Purpose: groups the control inputs and status outputs of bcd_countdown so
// the timer and its driver share one typed connection.
//
// Signals (widths for DIGITS digits, packed least-significant digit first):
//   load        1           load preset, highest priority
//   load_value  4*DIGITS    BCD preset
//   start       1           begin or resume counting
//   pause       1           stop counting, hold value
//   tick        1           decrement request, level sampled
//   value       4*DIGITS    current BCD count (registered)
//   running     1           counter is in RUN
//   zero        1           value equals zero
//   done        1           one-cycle expiry pulse
//
// Modports: master drives the controls (timer owner), slave is the timer.

interface bcd_countdown_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  start;
    logic                  pause;
    logic                  tick;
    logic [4*DIGITS-1:0]   value;
    logic                  running;
    logic                  zero;
    logic                  done;

    modport master (
        output load,
        output load_value,
        output start,
        output pause,
        output tick,
        input  value,
        input  running,
        input  zero,
        input  done
    );

    modport slave (
        input  load,
        input  load_value,
        input  start,
        input  pause,
        input  tick,
        output value,
        output running,
        output zero,
        output done
    );
endinterface

// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - multi-digit BCD down-counter with load, start/pause and expiry pulse
//
// Purpose: voting-session countdown timer. A BCD preset is loaded, the count
// drops by one per tick while running, and a single-cycle done pulse marks
// the step that reaches zero. Once expired the counter sits at zero until it
// is reloaded or reset.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   bus     slave modport of bcd_countdown_if:
//           load/load_value/start/pause/tick in, value/running/zero/done out

module bcd_countdown #(
    parameter int DIGITS = 2
) (
    input  logic           clock,
    input  logic           reset,
    bcd_countdown_if.slave bus
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   value_q, value_d;
    logic           done_q,  done_d;

    logic [W-1:0]   load_clean;
    logic [W-1:0]   value_dec;
    logic           value_is_zero;
    logic           dec_is_zero;

    // Preset sanitizing: a non-decimal nibble would break the borrow rule,
    // so it is clamped to the largest legal digit.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_value[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd9;
            end else begin
                load_clean[4*i +: 4] = bus.load_value[4*i +: 4];
            end
        end
    end

    // Ripple-borrow BCD decrement. The tick is the borrow into the least
    // significant digit; a digit at 0 that receives a borrow wraps to 9 and
    // passes the borrow upward. The whole chain settles in one cycle.
    always_comb begin
        logic borrow;
        logic [3:0] digit;
        value_dec = '0;
        borrow    = bus.tick;
        for (int i = 0; i < DIGITS; i++) begin
            digit = value_q[4*i +: 4];
            if (borrow) begin
                if (digit == 4'd0) begin
                    value_dec[4*i +: 4] = 4'd9;
                    borrow              = 1'b1;
                end else begin
                    value_dec[4*i +: 4] = digit - 4'd1;
                    borrow              = 1'b0;
                end
            end else begin
                value_dec[4*i +: 4] = digit;
            end
        end
    end

    assign value_is_zero = (value_q == '0);
    assign dec_is_zero   = (value_dec == '0);

    // Next-state logic. Load overrides everything; within RUN, pause
    // overrides tick. RUN is never entered with a zero count, so the
    // decrement can never underflow.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        done_d  = 1'b0;

        if (bus.load) begin
            value_d = load_clean;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start && !value_is_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_IDLE;
                    end else if (bus.tick) begin
                        value_d = value_dec;
                        if (dec_is_zero) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.zero    = value_is_zero;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// tb/tb_bcd_countdown.sv - directed self-checking bench for bcd_countdown

module tb_bcd_countdown;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    bcd_countdown_if #(.DIGITS(2)) bus ();

    bcd_countdown #(.DIGITS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        step();
        bus.load       = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = 8'h00;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.tick       = 1'b0;

        step();
        step();
        check("rst_value",   bus.value,   8'h00);
        check("rst_running", bus.running, 1'b0);
        check("rst_done",    bus.done,    1'b0);
        check("rst_zero",    bus.zero,    1'b1);
        reset = 1'b0;
        step();
        check("rst_rel_done", bus.done, 1'b0);

        // 1: 12 down to 00 with held tick
        do_load(8'h12);
        check("s1_load", bus.value, 8'h12);
        check("s1_idle", bus.running, 1'b0);
        do_start();
        check("s1_run", bus.running, 1'b1);
        bus.tick = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("s1_val%0d", i),  bus.value,   to_bcd(12 - i));
            check($sformatf("s1_done%0d", i), bus.done,    (i == 12) ? 1'b1 : 1'b0);
            check($sformatf("s1_run%0d", i),  bus.running, (i == 12) ? 1'b0 : 1'b1);
        end
        check("s1_zero", bus.zero, 1'b1);
        // expired: tick and start ignored, done stays low
        bus.start = 1'b1;
        step();
        check("s5_exp_done", bus.done, 1'b0);
        step();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        check("s5_exp_val", bus.value,   8'h00);
        check("s5_exp_run", bus.running, 1'b0);
        do_load(8'h30);
        check("s5_reload_val", bus.value,   8'h30);
        check("s5_reload_run", bus.running, 1'b0);

        // 2: borrow across digit boundary
        do_load(8'h10);
        do_start();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        check("s2_val", bus.value, 8'h09);
        check("s2_done", bus.done, 1'b0);

        // 3: illegal digit clamped
        do_load(8'hA5);
        check("s3_clamp", bus.value, 8'h95);
        do_load(8'h5C);
        check("s3_clamp_lsd", bus.value, 8'h59);
        do_load(8'hA5);
        do_start();
        bus.tick = 1'b1;
        step();
        step();
        step();
        bus.tick = 1'b0;
        check("s3_val", bus.value, 8'h92);

        // 4: pause beats tick, resume
        do_load(8'h05);
        do_start();
        bus.tick = 1'b1;
        step();
        step();
        check("s4_val03", bus.value, 8'h03);
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        check("s4_pause_val", bus.value,   8'h03);
        check("s4_pause_run", bus.running, 1'b0);
        step();
        step();
        check("s4_idle_tick", bus.value, 8'h03);
        bus.tick = 1'b0;
        do_start();
        check("s4_resume", bus.running, 1'b1);
        bus.tick = 1'b1;
        step();
        check("s4_v02", bus.value, 8'h02);
        step();
        check("s4_v01", bus.value, 8'h01);
        check("s4_d01", bus.done,  1'b0);
        step();
        bus.tick = 1'b0;
        check("s4_v00", bus.value, 8'h00);
        check("s4_d00", bus.done,  1'b1);
        step();
        check("s4_dpulse", bus.done, 1'b0);

        // 5: start with zero stays idle
        do_load(8'h00);
        do_start();
        check("s5_zero_run", bus.running, 1'b0);
        check("s5_zero_done", bus.done,   1'b0);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        check("s5_zero_done2", bus.done, 1'b0);
        check("s5_zero_flag",  bus.zero, 1'b1);

        // 6: async reset mid-count, then load beats tick
        do_load(8'h40);
        do_start();
        bus.tick = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("s6_val35", bus.value, 8'h35);
        #2;
        reset = 1'b1;
        #1;
        check("s6_arst_val", bus.value,   8'h00);
        check("s6_arst_run", bus.running, 1'b0);
        check("s6_arst_done", bus.done,   1'b0);
        #1;
        reset    = 1'b0;
        bus.tick = 1'b0;
        step();
        check("s6_post_done", bus.done, 1'b0);
        check("s6_post_val",  bus.value, 8'h00);
        do_load(8'h40);
        do_start();
        bus.tick = 1'b1;
        do_load(8'h27);
        bus.tick = 1'b0;
        check("s6_load_wins", bus.value,   8'h27);
        check("s6_load_idle", bus.running, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
Multi-digit BCD down-counter with load, start/pause control and a terminal-count pulse. It is the decrementing counterpart of the team's BCD up-counter, and is used as the voting-session countdown timer. It is loaded with a BCD preset, counts down one unit per tick while running, and flags expiry when it reaches zero. Digits are packed least-significant digit in bits [3:0].

Parameters:
DIGITS, 2, number of BCD digits; value width is 4*DIGITS.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
load  input  1  load preset; highest priority.
load_value  input  4*DIGITS  BCD preset, packed LSD first.
start  input  1  begin or resume counting.
pause  input  1  stop counting and hold the value.
tick  input  1  decrement request, sampled as a level; each high cycle counts once.
value  output  4*DIGITS  current BCD count, registered.
running  output  1  high while in state RUN.
zero  output  1  high when value == 0; combinational from the value register.
done  output  1  registered one-cycle pulse on expiry.

Behaviour:
- Reset is async and active-high; clock is `clock`.
  - On reset: value=0, state=IDLE, running=0, done=0, so zero=1.
  - Reset mid-count aborts immediately.
  - No done pulse is generated on or after reset release.
- States: IDLE, RUN, EXPIRED. Encoding is free; running = (state==RUN).
- Load (any state, priority over start, pause and tick):
  - value <= sanitized load_value; any digit > 9 is replaced by 9.
  - state <= IDLE; done <= 0.
- IDLE:
  - start=1 and value != 0 -> RUN.
  - start=1 and value == 0 -> stay IDLE; no done pulse.
  - tick is ignored.
  - pause is ignored.
- RUN:
  - pause=1 -> IDLE with value held. pause beats tick and start in the same cycle.
  - Otherwise tick=1 -> value <= value - 1 in BCD. The update is visible the cycle after tick is sampled.
  - If the decremented value is 0 -> state <= EXPIRED and done <= 1 on the same edge. done lasts exactly one cycle.
  - start is ignored.
- EXPIRED:
  - value is held at 0; tick, start and pause are ignored.
  - Leaves only via load or reset.
- BCD decrement rule:
  - Digit 0 with borrow-in -> 9 with borrow-out; otherwise digit-1 with no borrow.
  - Borrow-in to digit 0 is tick; borrow ripples LSD to MSD within one cycle.
  - Never decrements below 0; RUN is never entered with value 0.
- done is 0 in every cycle except the single expiry cycle.
- Throughput: one decrement per clock when tick is held high.

Test Plan:
1. Reset, then DIGITS=2, load 8'h12, start, hold tick 12 cycles.
   - value steps 12,11,10,09,...,01,00.
   - done=1 only in the cycle value first reads 00; running drops the same cycle; zero=1.
2. Load 8'h10, start, one tick.
   - value=09; the borrow crosses the digit boundary.
3. Load 8'hA5.
   - value=95; illegal digit clamped.
   - start, then 3 ticks gives 92.
4. Load 8'h05, start, 2 ticks -> 03.
   - pause together with tick -> IDLE, value stays 03.
   - Further ticks are ignored; start resumes; 3 ticks give 00 with done pulse.
5. Load 8'h00, start.
   - Stays IDLE, running=0, done never asserts.
   - After expiry in scenario 1, ticks and start keep value=00 until load 8'h30 gives IDLE with 30.
6. Load 8'h40, start, 5 ticks, then reset asserted between clock edges.
   - value=00, running=0, done=0 immediately.
   - load and tick in the same cycle: load wins, value = load_value.
